// File: rtl/spi_reg_arbiter.sv
// Round-robin arbiter sharing one register bank between an SPI slave front end
// (strobed, one-deep pending buffer) and a local host (req/ack handshake).
//
// state  | meaning
// -------+--------------------------------------------------------------
// IDLE   | no access in flight; pick a requester (round-robin on ties)
// ACCESS | rb_en high for one cycle with the winner's fields
// DONE   | ack/rvalid pulsed to the winner; read data captured on exit
module spi_reg_arbiter #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              spi_valid,
    input  logic              spi_we,
    input  logic [ADDR_W-1:0] spi_addr,
    input  logic [DATA_W-1:0] spi_wdata,
    output logic              spi_rvalid,
    output logic [DATA_W-1:0] spi_rdata,
    input  logic              host_req,
    input  logic              host_we,
    input  logic [ADDR_W-1:0] host_addr,
    input  logic [DATA_W-1:0] host_wdata,
    output logic              host_ack,
    output logic [DATA_W-1:0] host_rdata,
    output logic              rb_en,
    output logic              rb_we,
    output logic [ADDR_W-1:0] rb_addr,
    output logic [DATA_W-1:0] rb_wdata,
    input  logic [DATA_W-1:0] rb_rdata,
    output logic              ovf,
    input  logic              ovf_clr
);

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        DONE
    } state_t;

    state_t            state;
    logic              spi_pend;
    logic              pend_we;
    logic [ADDR_W-1:0] pend_addr;
    logic [DATA_W-1:0] pend_wdata;
    logic              last_spi;
    logic              cur_spi;

    logic              spi_win;
    logic              host_win;
    logic              spi_drop;

    // SPI wins when alone, or on a tie when the host was served last.
    always_comb begin
        spi_win  = 1'b0;
        host_win = 1'b0;
        if (state == IDLE) begin
            spi_win  = spi_pend && (!host_req || !last_spi);
            host_win = host_req && !spi_win;
        end
        spi_drop = spi_valid && spi_pend && !spi_win;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            spi_pend   <= 1'b0;
            pend_we    <= 1'b0;
            pend_addr  <= '0;
            pend_wdata <= '0;
            last_spi   <= 1'b0;
            cur_spi    <= 1'b0;
            ovf        <= 1'b0;
            rb_en      <= 1'b0;
            rb_we      <= 1'b0;
            rb_addr    <= '0;
            rb_wdata   <= '0;
            host_ack   <= 1'b0;
            spi_rvalid <= 1'b0;
            spi_rdata  <= '0;
            host_rdata <= '0;
        end else begin
            host_ack   <= 1'b0;
            spi_rvalid <= 1'b0;

            // A strobe arriving while the buffer is being drained refills it.
            if (spi_valid && !spi_drop) begin
                spi_pend   <= 1'b1;
                pend_we    <= spi_we;
                pend_addr  <= spi_addr;
                pend_wdata <= spi_wdata;
            end else if (spi_win) begin
                spi_pend <= 1'b0;
            end

            if (spi_drop) begin
                ovf <= 1'b1;
            end else if (ovf_clr) begin
                ovf <= 1'b0;
            end

            case (state)
                IDLE: begin
                    if (spi_win || host_win) begin
                        state    <= ACCESS;
                        rb_en    <= 1'b1;
                        cur_spi  <= spi_win;
                        last_spi <= spi_win;
                        rb_we    <= spi_win ? pend_we    : host_we;
                        rb_addr  <= spi_win ? pend_addr  : host_addr;
                        rb_wdata <= spi_win ? pend_wdata : host_wdata;
                    end
                end
                ACCESS: begin
                    state <= DONE;
                    rb_en <= 1'b0;
                    if (cur_spi) begin
                        spi_rvalid <= 1'b1;
                    end else begin
                        host_ack <= 1'b1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                    // Bank read data is valid during DONE; writes leave rdata untouched.
                    if (!rb_we) begin
                        if (cur_spi) begin
                            spi_rdata <= rb_rdata;
                        end else begin
                            host_rdata <= rb_rdata;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_spi_reg_arbiter.sv
// Directed bench for spi_reg_arbiter with a one-cycle-latency register bank model.
module tb_spi_reg_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        spi_valid;
    logic        spi_we;
    logic [7:0]  spi_addr;
    logic [31:0] spi_wdata;
    logic        spi_rvalid;
    logic [31:0] spi_rdata;
    logic        host_req;
    logic        host_we;
    logic [7:0]  host_addr;
    logic [31:0] host_wdata;
    logic        host_ack;
    logic [31:0] host_rdata;
    logic        rb_en;
    logic        rb_we;
    logic [7:0]  rb_addr;
    logic [31:0] rb_wdata;
    logic [31:0] rb_rdata;
    logic        ovf;
    logic        ovf_clr;

    int total = 0;
    int bad   = 0;

    bit [31:0] mem [256];

    spi_reg_arbiter #(.DATA_W(32), .ADDR_W(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .spi_valid  (spi_valid),
        .spi_we     (spi_we),
        .spi_addr   (spi_addr),
        .spi_wdata  (spi_wdata),
        .spi_rvalid (spi_rvalid),
        .spi_rdata  (spi_rdata),
        .host_req   (host_req),
        .host_we    (host_we),
        .host_addr  (host_addr),
        .host_wdata (host_wdata),
        .host_ack   (host_ack),
        .host_rdata (host_rdata),
        .rb_en      (rb_en),
        .rb_we      (rb_we),
        .rb_addr    (rb_addr),
        .rb_wdata   (rb_wdata),
        .rb_rdata   (rb_rdata),
        .ovf        (ovf),
        .ovf_clr    (ovf_clr)
    );

    always #5 clk = ~clk;

    // Register bank: synchronous read, data valid the cycle after rb_en.
    always @(posedge clk) begin
        if (rst) begin
            mem[4] <= 32'h1234_5678;
        end else if (rb_en) begin
            if (rb_we) mem[rb_addr] <= rb_wdata;
            rb_rdata <= mem[rb_addr];
        end
    end

    task automatic step();
        @(negedge clk);
    endtask

    task automatic do_reset();
        step();
        rst = 1'b1; spi_valid = 1'b0; spi_we = 1'b0; spi_addr = '0; spi_wdata = '0;
        host_req = 1'b0; host_we = 1'b0; host_addr = '0; host_wdata = '0; ovf_clr = 1'b0;
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        rst = 1'b1;
        step();
        total++; if (rb_en !== 1'b0)      begin bad++; $display("FAIL reset_rb_en got %b want 0", rb_en); end
        total++; if (rb_we !== 1'b0)      begin bad++; $display("FAIL reset_rb_we got %b want 0", rb_we); end
        total++; if (rb_addr !== 8'h0)    begin bad++; $display("FAIL reset_rb_addr got %h want 00", rb_addr); end
        total++; if (rb_wdata !== 32'h0)  begin bad++; $display("FAIL reset_rb_wdata got %h want 0", rb_wdata); end
        total++; if (host_ack !== 1'b0)   begin bad++; $display("FAIL reset_host_ack got %b want 0", host_ack); end
        total++; if (spi_rvalid !== 1'b0) begin bad++; $display("FAIL reset_spi_rvalid got %b want 0", spi_rvalid); end
        total++; if (spi_rdata !== 32'h0) begin bad++; $display("FAIL reset_spi_rdata got %h want 0", spi_rdata); end
        total++; if (host_rdata !== 32'h0) begin bad++; $display("FAIL reset_host_rdata got %h want 0", host_rdata); end
        total++; if (ovf !== 1'b0)        begin bad++; $display("FAIL reset_ovf got %b want 0", ovf); end
        rst = 1'b0;
    endtask

    // Host write then read of 0x10: rb_en at k+1, host_ack at k+2.
    task automatic test_host_rw();
        step();
        host_req = 1'b1; host_we = 1'b1; host_addr = 8'h10; host_wdata = 32'hDEAD_BEEF;
        total++; if (rb_en !== 1'b0) begin bad++; $display("FAIL hw_k0_rb_en got %b want 0", rb_en); end
        step();
        total++; if ({rb_en, rb_we} !== 2'b11) begin bad++; $display("FAIL hw_k1_en_we got %b want 11", {rb_en, rb_we}); end
        total++; if (rb_addr !== 8'h10) begin bad++; $display("FAIL hw_k1_addr got %h want 10", rb_addr); end
        total++; if (rb_wdata !== 32'hDEAD_BEEF) begin bad++; $display("FAIL hw_k1_wdata got %h want deadbeef", rb_wdata); end
        total++; if (host_ack !== 1'b0) begin bad++; $display("FAIL hw_k1_ack got %b want 0", host_ack); end
        step();
        total++; if ({host_ack, rb_en} !== 2'b10) begin bad++; $display("FAIL hw_k2_ack_en got %b want 10", {host_ack, rb_en}); end
        host_req = 1'b0;
        step();
        total++; if (host_ack !== 1'b0) begin bad++; $display("FAIL hw_k3_ack got %b want 0", host_ack); end
        host_req = 1'b1; host_we = 1'b0;
        step();
        total++; if ({rb_en, rb_we} !== 2'b10) begin bad++; $display("FAIL hr_k1_en_we got %b want 10", {rb_en, rb_we}); end
        step();
        total++; if (host_ack !== 1'b1) begin bad++; $display("FAIL hr_k2_ack got %b want 1", host_ack); end
        host_req = 1'b0;
        step();
        total++; if (host_rdata !== 32'hDEAD_BEEF) begin bad++; $display("FAIL hr_rdata got %h want deadbeef", host_rdata); end
    endtask

    // SPI read of 0x04: rb_en two cycles after the strobe, rvalid three.
    task automatic test_spi_read();
        spi_valid = 1'b1; spi_we = 1'b0; spi_addr = 8'h04;
        step();
        spi_valid = 1'b0;
        total++; if (rb_en !== 1'b0) begin bad++; $display("FAIL sr_k1_rb_en got %b want 0", rb_en); end
        step();
        total++; if ({rb_en, rb_we} !== 2'b10) begin bad++; $display("FAIL sr_k2_en_we got %b want 10", {rb_en, rb_we}); end
        total++; if (rb_addr !== 8'h04) begin bad++; $display("FAIL sr_k2_addr got %h want 04", rb_addr); end
        total++; if (spi_rvalid !== 1'b0) begin bad++; $display("FAIL sr_k2_rvalid got %b want 0", spi_rvalid); end
        step();
        total++; if (spi_rvalid !== 1'b1) begin bad++; $display("FAIL sr_k3_rvalid got %b want 1", spi_rvalid); end
        total++; if (host_ack !== 1'b0) begin bad++; $display("FAIL sr_k3_host_ack got %b want 0", host_ack); end
        step();
        total++; if (spi_rvalid !== 1'b0) begin bad++; $display("FAIL sr_k4_rvalid got %b want 0", spi_rvalid); end
        total++; if (spi_rdata !== 32'h1234_5678) begin bad++; $display("FAIL sr_rdata got %h want 12345678", spi_rdata); end
        total++; if (host_rdata !== 32'hDEAD_BEEF) begin bad++; $display("FAIL sr_host_rdata_held got %h want deadbeef", host_rdata); end
    endtask

    // Ties after reset: SPI first, then alternating S,H,S,H.
    task automatic test_round_robin();
        do_reset();
        spi_valid = 1'b1; spi_we = 1'b1; spi_addr = 8'h20; spi_wdata = 32'hA;
        step();
        spi_valid = 1'b0;
        host_req = 1'b1; host_we = 1'b1; host_addr = 8'h30; host_wdata = 32'hB;
        step();
        total++; if ({rb_en, rb_addr} !== {1'b1, 8'h20}) begin bad++; $display("FAIL rr_first_spi got %b/%h want 1/20", rb_en, rb_addr); end
        spi_valid = 1'b1; spi_addr = 8'h24;
        step();
        spi_valid = 1'b0;
        total++; if ({spi_rvalid, host_ack} !== 2'b10) begin bad++; $display("FAIL rr_first_done got %b want 10", {spi_rvalid, host_ack}); end
        step();
        step();
        total++; if ({rb_en, rb_addr} !== {1'b1, 8'h30}) begin bad++; $display("FAIL rr_second_host got %b/%h want 1/30", rb_en, rb_addr); end
        step();
        total++; if ({spi_rvalid, host_ack} !== 2'b01) begin bad++; $display("FAIL rr_second_done got %b want 01", {spi_rvalid, host_ack}); end
        step();
        step();
        total++; if ({rb_en, rb_addr} !== {1'b1, 8'h24}) begin bad++; $display("FAIL rr_third_spi got %b/%h want 1/24", rb_en, rb_addr); end
        step();
        total++; if (spi_rvalid !== 1'b1) begin bad++; $display("FAIL rr_third_done got %b want 1", spi_rvalid); end
        step();
        step();
        total++; if ({rb_en, rb_addr} !== {1'b1, 8'h30}) begin bad++; $display("FAIL rr_fourth_host got %b/%h want 1/30", rb_en, rb_addr); end
        step();
        total++; if (host_ack !== 1'b1) begin bad++; $display("FAIL rr_fourth_done got %b want 1", host_ack); end
        host_req = 1'b0;
        step();
        step();
        total++; if (rb_en !== 1'b0) begin bad++; $display("FAIL rr_quiet got %b want 0", rb_en); end
    endtask

    // Two strobes on consecutive cycles while the host is in flight; the second is dropped.
    task automatic test_overflow(input bit clr_in_drop);
        int extra;
        extra = 0;
        host_req = 1'b1; host_we = 1'b0; host_addr = 8'h10;
        step();
        total++; if (rb_en !== 1'b1) begin bad++; $display("FAIL ov_host_access got %b want 1", rb_en); end
        spi_valid = 1'b1; spi_we = 1'b0; spi_addr = 8'h04;
        step();
        total++; if (host_ack !== 1'b1) begin bad++; $display("FAIL ov_host_ack got %b want 1", host_ack); end
        host_req = 1'b0; spi_addr = 8'h08; ovf_clr = clr_in_drop;
        step();
        spi_valid = 1'b0; ovf_clr = 1'b0;
        total++; if (ovf !== 1'b1) begin bad++; $display("FAIL ov_set clr=%0d got %b want 1", clr_in_drop, ovf); end
        total++; if (host_rdata !== 32'hDEAD_BEEF) begin bad++; $display("FAIL ov_host_rdata got %h want deadbeef", host_rdata); end
        step();
        total++; if ({rb_en, rb_addr} !== {1'b1, 8'h04}) begin bad++; $display("FAIL ov_kept_buffer got %b/%h want 1/04", rb_en, rb_addr); end
        step();
        total++; if (spi_rvalid !== 1'b1) begin bad++; $display("FAIL ov_rvalid got %b want 1", spi_rvalid); end
        for (int i = 0; i < 4; i++) begin
            step();
            if (rb_en || spi_rvalid || host_ack) extra++;
        end
        total++; if (extra !== 0) begin bad++; $display("FAIL ov_no_second_access got %0d want 0", extra); end
        total++; if (ovf !== 1'b1) begin bad++; $display("FAIL ov_sticky got %b want 1", ovf); end
        ovf_clr = 1'b1;
        step();
        ovf_clr = 1'b0;
        total++; if (ovf !== 1'b0) begin bad++; $display("FAIL ov_clear got %b want 0", ovf); end
    endtask

    // Reset while the host access is in ACCESS with an SPI request buffered.
    task automatic test_reset_mid();
        int extra;
        extra = 0;
        host_req = 1'b1; host_we = 1'b1; host_addr = 8'h40; host_wdata = 32'h55;
        spi_valid = 1'b1; spi_we = 1'b0; spi_addr = 8'h04;
        step();
        spi_valid = 1'b0;
        total++; if (rb_en !== 1'b1) begin bad++; $display("FAIL rm_access got %b want 1", rb_en); end
        rst = 1'b1; host_req = 1'b0;
        step();
        rst = 1'b0;
        total++; if ({rb_en, rb_we, host_ack, spi_rvalid, ovf} !== 5'b0) begin bad++; $display("FAIL rm_flags got %b want 00000", {rb_en, rb_we, host_ack, spi_rvalid, ovf}); end
        total++; if ({rb_addr, rb_wdata} !== 40'h0) begin bad++; $display("FAIL rm_rb_fields got %h/%h want 0/0", rb_addr, rb_wdata); end
        total++; if ({spi_rdata, host_rdata} !== 64'h0) begin bad++; $display("FAIL rm_rdata got %h/%h want 0/0", spi_rdata, host_rdata); end
        for (int i = 0; i < 5; i++) begin
            step();
            if (rb_en || spi_rvalid || host_ack) extra++;
        end
        total++; if (extra !== 0) begin bad++; $display("FAIL rm_pend_discarded got %0d want 0", extra); end
    endtask

    // Host held high; three SPI strobes four cycles apart. Expected completions
    // H@2, S@5, H@8, S@11, H@14, S@17 relative to the first host request.
    task automatic test_sustained();
        int acks, rvals, ovf_seen, alt_err, last_kind;
        acks = 0; rvals = 0; ovf_seen = 0; alt_err = 0; last_kind = -1;
        do_reset();
        host_we = 1'b1; host_addr = 8'h50; host_wdata = 32'h77;
        spi_we = 1'b0; spi_addr = 8'h04;
        for (int c = 0; c < 20; c++) begin
            if (c > 0) step();
            if (ovf) ovf_seen++;
            if (host_ack) begin
                acks++;
                if (last_kind == 0) alt_err++;
                last_kind = 0;
            end
            if (spi_rvalid) begin
                rvals++;
                if (last_kind == 1) alt_err++;
                last_kind = 1;
            end
            host_req  = 1'b1;
            spi_valid = (c == 2 || c == 6 || c == 10);
        end
        step();
        spi_valid = 1'b0; host_req = 1'b0;
        total++; if (rvals !== 3) begin bad++; $display("FAIL sus_rvalid_count got %0d want 3", rvals); end
        total++; if (acks !== 3) begin bad++; $display("FAIL sus_ack_count got %0d want 3", acks); end
        total++; if (alt_err !== 0) begin bad++; $display("FAIL sus_alternate got %0d want 0", alt_err); end
        total++; if (ovf_seen !== 0) begin bad++; $display("FAIL sus_no_ovf got %0d want 0", ovf_seen); end
        for (int i = 0; i < 4; i++) step();
    endtask

    initial begin
        test_reset();
        test_host_rw();
        test_spi_read();
        test_round_robin();
        test_overflow(1'b0);
        test_overflow(1'b1);
        test_reset_mid();
        test_sustained();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/spi_reg_arbiter.md
SPI_REG_ARBITER -- requirements
Module: spi_reg_arbiter

Interface
REQ-001 Parameter DATA_W, default 32, register data width in bits.
REQ-002 Parameter ADDR_W, default 8, register address width in bits.
REQ-003 clk  input  1  single system clock; all logic on its rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 spi_valid  input  1  one-cycle strobe from the SPI slave protocol layer marking a register access.
REQ-006 spi_we  input  1  SPI access is a write when 1, a read when 0; qualified by spi_valid.
REQ-007 spi_addr  input  ADDR_W  SPI access address; qualified by spi_valid.
REQ-008 spi_wdata  input  DATA_W  SPI write data; qualified by spi_valid.
REQ-009 spi_rvalid  output  1  one-cycle strobe marking SPI access completion; spi_rdata valid for reads.
REQ-010 spi_rdata  output  DATA_W  read data returned to the SPI slave.
REQ-011 host_req  input  1  local host request, held high until host_ack.
REQ-012 host_we, host_addr, host_wdata  input  1/ADDR_W/DATA_W  host access fields, stable while host_req is high.
REQ-013 host_ack  output  1  one-cycle completion strobe to the host.
REQ-014 host_rdata  output  DATA_W  read data returned to the host.
REQ-015 rb_en, rb_we  output  1/1  register-bank access strobe and write enable.
REQ-016 rb_addr, rb_wdata  output  ADDR_W/DATA_W  register-bank address and write data.
REQ-017 rb_rdata  input  DATA_W  register-bank read data, valid exactly one cycle after rb_en.
REQ-018 ovf  output  1  sticky flag: an SPI request was dropped.
REQ-019 ovf_clr  input  1  clears ovf for one cycle.

Function
REQ-020 spi_valid SHALL capture spi_we/addr/wdata into a one-deep pending buffer and set spi_pend on the next edge.
REQ-021 spi_valid while spi_pend is set and not being granted in that cycle SHALL drop the new request and set ovf; the buffered request is kept.
REQ-022 spi_valid in the same cycle the buffered request is granted SHALL be accepted (spi_pend stays 1, buffer updated).
REQ-023 FSM states: IDLE, ACCESS, DONE; IDLE->ACCESS when spi_pend or host_req; ACCESS->DONE; DONE->IDLE unconditionally.
REQ-024 In IDLE with exactly one requester, that requester SHALL be granted.
REQ-025 In IDLE with both requesting, the requester not granted last SHALL win (round-robin); last_grant resets to HOST so SPI wins the first tie.
REQ-026 In ACCESS, rb_en SHALL be 1 for exactly one cycle with rb_we/rb_addr/rb_wdata registered from the granted requester.
REQ-027 In DONE, rb_rdata SHALL be registered into the winner's rdata output, and host_ack or spi_rvalid pulsed for that cycle; writes also pulse ack/rvalid, with rdata unchanged.
REQ-028 Latency: host_req high in IDLE at cycle k -> rb_en at k+1 -> host_ack at k+2; spi_valid at k (arbiter idle, no host) -> rb_en at k+2 -> spi_rvalid at k+3.
REQ-029 host_req still high in IDLE after its ack SHALL be treated as a new request; the host drops req in the cycle it sees host_ack.
REQ-030 rb_en SHALL be 0 in IDLE and DONE; at most one access is in flight.
REQ-031 ovf_clr and a new overflow in the same cycle SHALL leave ovf = 1.
REQ-032 spi_rdata/host_rdata SHALL hold their values until the next completed read for that requester.

Reset
REQ-033 rst SHALL force state IDLE, spi_pend 0, last_grant HOST, and ovf, rb_en, rb_we, host_ack, spi_rvalid 0; rb_addr, rb_wdata, spi_rdata, host_rdata 0.
REQ-034 rst mid-access SHALL abort: no ack/rvalid is issued, and the pending SPI request is discarded.

Verification
REQ-035 Host write 0xDEADBEEF to 0x10 then read 0x10 -> rb_en at k+1, host_ack at k+2 each, host_rdata = 0xDEADBEEF.
REQ-036 spi_valid read of 0x04 (bank returns 0x12345678) -> rb_en 2 cycles later, spi_rvalid 3 cycles after strobe, spi_rdata = 0x12345678.
REQ-037 spi_pend and host_req both high in IDLE after reset -> SPI granted first, host next; a repeated tie -> alternates.
REQ-038 Two spi_valid strobes 1 cycle apart while host access in ACCESS -> second dropped, ovf = 1; ovf_clr -> ovf = 0 next cycle.
REQ-039 rst asserted during ACCESS -> next cycle all outputs 0, no host_ack or spi_rvalid, spi_pend 0.
REQ-040 Sustained host_req with spi_valid every 4 cycles -> accesses alternate, no ovf, and every SPI strobe gets exactly one spi_rvalid.
